read_ram_controller: RTL
========================

Name: read_ram_controller

Overview:
Reads a completed packet image out of the packet buffer: header at addresses 0..HDR_SIZE-1, then the camera payload. Streams it byte by byte to the Ethernet transmit path over a valid/ready handshake. The source is either the frame RAM or the header/status ROM. This block is the read side paired with the camera-to-RAM write controller. A 2-entry skid FIFO hides the 1-cycle synchronous read latency and absorbs backpressure.

Parameters:
HDR_SIZE, 50, header bytes at addresses 0..HDR_SIZE-1
ETH_DATA_SIZE, 1280, payload bytes following the header
ADDR_W, 11, buffer address width; HDR_SIZE+ETH_DATA_SIZE must be <= 2**ADDR_W

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  1-cycle pulse: buffer is complete, begin sending
use_rom  in  1  source select; sampled only with an accepted start (1 = ROM, 0 = RAM)
ram_dout  in  8  RAM read data, valid 1 cycle after ram_rd_en
rom_dout  in  8  ROM read data, same timing as ram_dout
ram_addr  out  ADDR_W  read address, shared by RAM and ROM
ram_rd_en  out  1  read strobe
tx_data  out  8  stream byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts; a handshake occurs when tx_valid && tx_ready
tx_first  out  1  high with byte 0
tx_last  out  1  high with byte HDR_SIZE+ETH_DATA_SIZE-1
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse after the last handshake
FSM_state  out  2  current state, for debug

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0, including ram_addr. FIFO and counters are cleared. Reset mid-frame abandons the frame and produces no done pulse.
- TOTAL = HDR_SIZE+ETH_DATA_SIZE. Read address counter rd_addr runs 0..TOTAL-1 and never wraps. Output counter tx_cnt counts handshakes.
- States:
  - IDLE(0): on start go to READ. Latch use_rom, clear counters.
  - READ(1): issue reads. After the read with rd_addr=TOTAL-1 is issued, go to DRAIN.
  - DRAIN(2): no reads issued. When the handshake with tx_last occurs, go to DONE.
  - DONE(3): done=1 for exactly one cycle, then IDLE.
- busy=1 in READ, DRAIN and DONE. start while busy is ignored. use_rom is ignored outside an accepted start.
- Read issue rule, in READ: ram_rd_en=1 when (fifo_count + inflight - pop) < 2.
  - pop = tx_valid && tx_ready.
  - inflight = 1 if ram_rd_en was 1 in the previous cycle.
  - ram_addr = rd_addr while ram_rd_en=1. rd_addr increments after each issued read.
- Capture: in the cycle after ram_rd_en, the latched source (rom_dout or ram_dout) is pushed into the FIFO. The issue rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- Output: tx_valid = FIFO non-empty and tx_data = FIFO head.
  - Once tx_valid=1, tx_data, tx_first and tx_last stay stable until the handshake.
  - tx_first = (tx_cnt==0). tx_last = (tx_cnt==TOTAL-1).
- Latency: start high in cycle 0 -> ram_rd_en=1 with addr 0 in cycle 1 -> tx_valid=1 with byte 0 in cycle 2.
- Throughput: with tx_ready held high, 1 byte per cycle, so TOTAL consecutive handshakes. done is asserted in the cycle after the tx_last handshake.
- tx_ready=0 indefinitely: at most 2 reads outstanding in total (FIFO plus in flight); ram_rd_en stays 0 after that.

Decomposition:
- Shared package: FSM state constants (IDLE/READ/DRAIN/DONE), default HDR_SIZE, and the source-select encoding. The write controller also uses these.
- One sub-module, byte_skid_fifo: 2-entry, 8-bit FIFO with push, pop, count, head data, same clk/reset.

Test Plan:
1. RAM[i]=i[7:0], use_rom=0, start, tx_ready=1.
   - tx_valid first rises in cycle 2.
   - 1330 contiguous bytes 0x00,0x01,...; tx_first on byte 0; tx_last on byte 1329 (0x31).
   - done 1 cycle after the last handshake; busy=0 the cycle after that.
2. Random tx_ready at 30% duty.
   - Byte order is identical to case 1.
   - fifo_count+inflight never exceeds 2.
   - tx_data is stable whenever tx_valid=1 and tx_ready=0.
3. ROM[i]=~i, use_rom=1 at start; use_rom toggled mid-frame.
   - All bytes come from ROM (~i).
4. Second start pulse at byte 400.
   - Ignored: stream continues, exactly one done pulse, 1330 bytes total.
5. tx_ready=0 for 100 cycles after start.
   - Exactly 2 reads issued (addr 0,1); tx_valid=1 with byte 0x00 held stable.
   - On release, bytes stream in order.
6. reset=0 asynchronously at byte 600.
   - All outputs 0 immediately; no done pulse.
   - After release, a new start restarts at addr 0 with tx_first on byte 0x00.

Source files
------------

// File: rtl/read_ram_controller_pkg.sv
// Shared definitions for the packet-buffer read/write controllers:
// FSM state encoding, default packet geometry and source-select encoding.
package read_ram_controller_pkg;

    localparam int HDR_SIZE_DEFAULT      = 50;
    localparam int ETH_DATA_SIZE_DEFAULT = 1280;
    localparam int ADDR_W_DEFAULT        = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_ROM = 1'b1
    } src_sel_t;

endpackage

// File: rtl/read_ram_controller_byte_skid_fifo.sv
// Two-entry byte FIFO kept as a shift pair: entry 0 is always the head,
// so the head byte cannot change while it waits to be popped.
module byte_skid_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [1:0] count,
    output logic [7:0] head
);

    logic [7:0] ent0_q, ent0_d;
    logic [7:0] ent1_q, ent1_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (pop) begin
            ent0_d = ent1_q;
        end
        // On simultaneous push/pop the new byte lands behind whatever survives the pop
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = push_data;
                else                 ent1_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: count_d = count_q - 2'd1;
            2'b11: begin
                if (count_q == 2'd1) ent0_d = push_data;
                else                 ent1_d = push_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = ent0_q;

    overflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && count_q == 2'd2));
    underflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(pop && count_q == 2'd0));

endmodule

// File: rtl/read_ram_controller.sv
// Streams a finished packet image (header then payload) out of the frame RAM
// or header ROM onto a valid/ready byte stream, hiding the 1-cycle read latency.
module read_ram_controller
    import read_ram_controller_pkg::*;
#(
    parameter int HDR_SIZE      = HDR_SIZE_DEFAULT,
    parameter int ETH_DATA_SIZE = ETH_DATA_SIZE_DEFAULT,
    parameter int ADDR_W        = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              use_rom,
    input  logic [7:0]        ram_dout,
    input  logic [7:0]        rom_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_first,
    output logic              tx_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        FSM_state
);

    localparam int TOTAL = HDR_SIZE + ETH_DATA_SIZE;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

    ctrl_state_t       state_q, state_d;
    src_sel_t          src_q, src_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] tx_cnt_q, tx_cnt_d;
    logic              inflight_q, inflight_d;

    logic [1:0] fifo_count;
    logic [7:0] fifo_head;
    logic [7:0] src_byte;
    logic       fifo_empty;
    logic       pop;
    logic       fifo_push;
    logic       fifo_pop;
    logic [2:0] occupancy;

    // A byte still in flight counts as valid output: when the FIFO is empty the
    // read data bypasses it, which gives the 2-cycle start-to-valid latency.
    assign src_byte   = (src_q == SRC_ROM) ? rom_dout : ram_dout;
    assign fifo_empty = (fifo_count == 2'd0);
    assign tx_valid   = !fifo_empty || inflight_q;
    assign tx_data    = !fifo_empty ? fifo_head : (inflight_q ? src_byte : 8'h00);
    assign pop        = tx_valid && tx_ready;
    assign fifo_pop   = pop && !fifo_empty;
    assign fifo_push  = inflight_q && !(pop && fifo_empty);
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};

    assign ram_rd_en  = (state_q == ST_READ) && ((occupancy - {2'b00, pop}) < 3'd2);
    assign ram_addr   = ram_rd_en ? rd_addr_q : '0;
    assign tx_first   = tx_valid && (tx_cnt_q == '0);
    assign tx_last    = tx_valid && (tx_cnt_q == LAST_IDX);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign FSM_state  = state_q;

    byte_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (src_byte),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        rd_addr_d  = rd_addr_q;
        tx_cnt_d   = pop ? tx_cnt_q + 1'b1 : tx_cnt_q;
        inflight_d = ram_rd_en;
        if (ram_rd_en && rd_addr_q != LAST_IDX) begin
            rd_addr_d = rd_addr_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_READ;
                    src_d     = src_sel_t'(use_rom);
                    rd_addr_d = '0;
                    tx_cnt_d  = '0;
                end
            end
            ST_READ: begin
                if (ram_rd_en && rd_addr_q == LAST_IDX) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && tx_last) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_RAM;
            rd_addr_q  <= '0;
            tx_cnt_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            rd_addr_q  <= rd_addr_d;
            tx_cnt_q   <= tx_cnt_d;
            inflight_q <= inflight_d;
        end
    end

endmodule
